// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sequencer sharing one signed W x W multiplier among NREQ requesters
// Operands are registered into the external multiplier and the product is captured after MUL_LAT settle cycles.
module mul_share_arbiter #(
    parameter int NREQ    = 2,
    parameter int W       = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic [2*W-1:0]      mul_p,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_product,
    output logic                busy
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt, id, gnt;
    logic [CW-1:0]  cnt;
    logic           gnt_found;
    logic           accept;
    logic [W-1:0]   sel_a, sel_b;

    // Rotating priority: scan ptr, ptr+1, ... and take the first valid requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_found && req_valid[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    gnt_found = 1'b1;
                    gnt       = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        ptr_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                ptr_nxt = IDW'((i + 1) % NREQ);
            end
        end
    end

    assign accept = (state == IDLE) && gnt_found;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_found && !rst) begin
                    state_nxt = CALC;
                    for (int i = 0; i < NREQ; i++) begin
                        req_ready[i] = (gnt == IDW'(i));
                    end
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands only move on accept, so the multiplier input is quiet for the whole settle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            id          <= '0;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a <= sel_a;
                        mul_b <= sel_b;
                        id    <= gnt;
                        ptr   <= ptr_nxt;
                        cnt   <= CW'(MUL_LAT - 1);
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        rsp_product <= mul_p;
                        rsp_id      <= id;
                        rsp_valid   <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 4;
    localparam int ML   = 1;
    localparam int IDW  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [W-1:0]      mul_a, mul_b;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_product;
    logic              busy;

    logic [NREQ-1:0]   v3 = '0;
    logic [NREQ-1:0]   rr3;
    logic [NREQ*W-1:0] a3 = '0;
    logic [NREQ*W-1:0] b3 = '0;
    logic [W-1:0]      ma3, mb3;
    logic [2*W-1:0]    mp3;
    logic              rv3;
    logic              rdy3 = 1'b1;
    logic [IDW-1:0]    rid3;
    logic [2*W-1:0]    rp3;
    logic              busy3;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        int             id;
        logic [2*W-1:0] p;
        int             due;
    } exp_t;

    exp_t q[$];

    mul_share_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(ML), .IDW(IDW)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .busy(busy)
    );

    mul_share_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(3), .IDW(IDW)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rr3),
        .req_a(a3), .req_b(b3), .mul_a(ma3), .mul_b(mb3), .mul_p(mp3),
        .rsp_valid(rv3), .rsp_ready(rdy3), .rsp_id(rid3),
        .rsp_product(rp3), .busy(busy3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mul_p = 8'(int'($signed(mul_a)) * int'($signed(mul_b)));

    // Slow multiplier stand-in: garbage until operands have been stable for two settle edges.
    logic [2*W-1:0] prev3 = '0;
    int             st3   = 0;
    always @(negedge clk) begin
        if ({ma3, mb3} != prev3) begin
            st3   <= 0;
            prev3 <= {ma3, mb3};
        end else if (st3 < 3) begin
            st3 <= st3 + 1;
        end
    end
    assign mp3 = (st3 >= 2) ? 8'(int'($signed(ma3)) * int'($signed(mb3))) : 8'hAA;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb;
        sa = int'(a) - (a[W-1] ? (1 << W) : 0);
        sb = int'(b) - (b[W-1] ? (1 << W) : 0);
        return (2*W)'(sa * sb);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference arbiter: a busy unit is one with an outstanding expected response.
    int              mptr = 0;
    int              idx, g;
    bit              found;
    logic [NREQ-1:0] exp_rdy;
    exp_t            ae;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mptr = 0;
        end else begin
            exp_rdy = '0;
            found   = 1'b0;
            g       = 0;
            if (q.size() == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (!found && req_valid[idx]) begin
                        found        = 1'b1;
                        g            = idx;
                        exp_rdy[idx] = 1'b1;
                    end
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (found) begin
                ae.id  = g;
                ae.p   = ref_mul(req_a[g*W +: W], req_b[g*W +: W]);
                ae.due = cyc + 1 + ML;
                q.push_back(ae);
                mptr = (g + 1) % NREQ;
            end
        end
    end

    exp_t me;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_mul_a", 32'(mul_a), 0);
            chk("rst_mul_b", 32'(mul_b), 0);
            chk("rst_rsp_product", 32'(rsp_product), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
        end else if (q.size() == 0) begin
            chk("idle_rsp_valid", 32'(rsp_valid), 0);
            chk("idle_busy", 32'(busy), 0);
        end else begin
            me = q[0];
            chk("busy", 32'(busy), 32'(cyc >= me.due - ML));
            if (cyc < me.due) begin
                chk("early_rsp_valid", 32'(rsp_valid), 0);
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 1);
                chk("rsp_id", 32'(rsp_id), 32'(me.id));
                chk("rsp_product", 32'(rsp_product), 32'(me.p));
                if (rsp_valid && rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic set_req(input logic [NREQ-1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
    endtask

    task automatic one(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        idle(4);
        if (r == 0) set_req(2'b01, a, b, 4'h0, 4'h0);
        else        set_req(2'b10, 4'h0, 4'h0, a, b);
        tick();
        req_valid = '0;
    endtask

    initial begin
        req_valid = 2'b11;
        #1 rst = 1'b1;
        repeat (3) tick();
        req_valid = '0;
        rst       = 1'b0;

        one(0, 4'h7, 4'h8);
        one(0, 4'h8, 4'h8);
        one(1, 4'hF, 4'hF);
        one(0, 4'h0, 4'h9);
        one(1, 4'h7, 4'h7);

        idle(4);
        req_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            req_a = NREQ*W'($urandom);
            req_b = NREQ*W'($urandom);
            tick();
        end

        idle(4);
        rsp_ready = 1'b0;
        set_req(2'b11, 4'h9, 4'h5, 4'h3, 4'hC);
        tick();
        tick();
        repeat (5) tick();
        rsp_ready = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < 300; i++) begin
            req_valid = NREQ'($urandom);
            req_a     = NREQ*W'($urandom);
            req_b     = NREQ*W'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            tick();
        end

        idle(4);
        set_req(2'b01, 4'h3, 4'h2, 4'h0, 4'h0);
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("calc_rst_busy", 32'(busy), 0);
        chk("calc_rst_rsp_valid", 32'(rsp_valid), 0);
        tick();
        rst = 1'b0;
        set_req(2'b11, 4'hA, 4'h6, 4'h5, 4'h5);
        tick();
        req_valid = '0;

        idle(4);
        rsp_ready = 1'b0;
        set_req(2'b01, 4'h6, 4'hB, 4'h0, 4'h0);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("resp_rst_busy", 32'(busy), 0);
        chk("resp_rst_rsp_valid", 32'(rsp_valid), 0);
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(2'b10, 4'h0, 4'h0, 4'hC, 4'h4);
        tick();
        req_valid = '0;

        idle(10);
        chk("drain", 32'(q.size()), 0);

        rdy3 = 1'b1;
        v3   = 2'b01;
        a3   = 8'h05;
        b3   = 8'h0D;
        @(negedge clk);
        chk("ml3_req_ready", 32'(rr3), 1);
        @(posedge clk);
        #1 v3 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ml3_mul_a", 32'(ma3), 5);
            chk("ml3_mul_b", 32'(mb3), 32'hD);
            chk("ml3_rsp_valid", 32'(rv3), 32'(k == 3));
        end
        chk("ml3_rsp_product", 32'(rp3), 32'hF1);
        chk("ml3_rsp_id", 32'(rid3), 0);
        @(negedge clk);
        chk("ml3_rsp_done", 32'(rv3), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
